exibe_sequencia: RTL and testbench
==================================

// Module: exibe_sequencia
// PURPOSE
//  Playback side of the memory-game datapath: it shows the stored sequence to the player,
//  where the datapath reads it back to check the player's jogadas.
//  - On iniciar, walks ROM addresses 0..limite.
//  - Drives each 4-bit ROM word onto leds for T_ON cycles, then blanks them for T_OFF cycles.
//  - Pulses pronto when the last item is done.
//  - Sits between the control unit and the shared sync_rom_16x4 read port.
// PARAMETERS
//  T_ON    default 500  cycles leds show the current word (>=1)
//  T_OFF   default 250  cycles leds are blank between words (>=1)
//  TW      default 10   timer width; must satisfy 2**TW > max(T_ON,T_OFF)
// PORTS
//  clock     in   1  rising-edge clock
//  reset     in   1  asynchronous reset, active-low
//  iniciar   in   1  start request, sampled only in OCIOSO
//  limite    in   4  index of last item to show (0..15); latched on start
//  endereco  out  4  ROM address; ROM returns dado one cycle later (synchronous read)
//  dado      in   4  ROM data word
//  leds      out  4  displayed word; 4'b0000 when blank
//  ocupado   out  1  high in every state except OCIOSO
//  pronto    out  1  one-cycle pulse when the sequence ends
//  db_estado out  4  state encoding, for debug display
// BEHAVIOUR
//  - Reset (async, any state): state=OCIOSO, endereco=0, leds=0, pronto=0, timer=0, lim_reg=0.
//  - OCIOSO:
//    - iniciar=1 -> LE_MEM; latch lim_reg<=limite; endereco<=0.
//    - iniciar while busy is ignored (not queued).
//  - LE_MEM (1 cycle): waits out the ROM latency. Next state ACENDE; leds<=dado on that edge.
//  - ACENDE:
//    - leds hold the word; timer counts 0..T_ON-1.
//    - At T_ON-1: timer<=0, leds<=0, -> APAGA.
//  - APAGA: leds=0; timer counts 0..T_OFF-1. At T_OFF-1:
//    - if endereco==lim_reg -> FIM;
//    - else endereco<=endereco+1 -> LE_MEM.
//  - FIM (1 cycle): pronto=1, ocupado=1 -> OCIOSO.
//    - An iniciar sampled in FIM is ignored.
//  - Timing: each item costs 1+T_ON+T_OFF cycles. pronto is high in the cycle that starts
//    (lim_reg+1)*(1+T_ON+T_OFF) rising edges after the edge that accepted iniciar.
//  - endereco never wraps: limite=15 ends at 15. limite=0 shows exactly one word.
//  - A dado of 0 is shown as blank for T_ON cycles and still counts as one item.
//  - Changing limite mid-run has no effect (lim_reg is used).
//  - Reset mid-run aborts immediately; pronto is not pulsed.
//  - All outputs are registered or decoded from state only; no combinational path from the inputs.
// CONFIGURATION
//  - PAUSA_EN defined: adds input `pausa` (1 bit).
//    - While pausa=1, state, timer and endereco hold, and leds keep their value.
//    - pausa has no effect in OCIOSO or FIM.
//    - Each paused cycle extends the pronto latency by one.
//  - PAUSA_EN undefined: the port is absent and timing is exactly as above.
// STRUCTURE
//  - Package exibe_pkg holds:
//    - state constants OCIOSO=4'h0, LE_MEM=4'h1, ACENDE=4'h2, APAGA=4'h3, FIM=4'hF;
//    - address/data width constants (4).
//  - One sub-module: the existing contador_m serves as the display timer, with zera_s driven
//    by the FSM and conta=ACENDE|APAGA.
//  - The FSM and address register stay in this module.
// TESTING
//  - T_ON=4, T_OFF=2, ROM={1,2,4,8}, limite=2, iniciar pulse:
//    - leds show 1,2,4, each for 4 cycles, with 2 blank cycles between;
//    - pronto rises 21 edges after the start edge; ocupado falls one cycle later.
//  - limite=0: exactly one word is shown; pronto comes after 7 edges; endereco stays 0.
//  - limite=15: endereco reaches 15 without wrapping; pronto comes after 112 edges.
//  - iniciar held high through the whole run: no restart until OCIOSO, then a new run
//    starts on the next edge.
//  - reset=0 during ACENDE of item 1: leds=0, ocupado=0 and endereco=0 at once; no pronto pulse.
//  - PAUSA_EN, pausa=1 for 5 cycles mid-ACENDE: the word is held; pronto is 5 cycles later
//    than the unpaused run.

Source files
------------

// File: rtl/exibe_pkg.sv
// Shared constants for the sequence playback block (exibe_sequencia).
// Holds the FSM state encoding, which is also shown on db_estado, and the
// ROM address/data widths.
package exibe_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  typedef enum logic [3:0] {
    OCIOSO = 4'h0,
    LE_MEM = 4'h1,
    ACENDE = 4'h2,
    APAGA  = 4'h3,
    FIM    = 4'hF
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// contador_m: free-running up-counter that serves as the display timer.
// Ports:
//   clock    in  rising-edge clock
//   zera_as  in  asynchronous clear, active-low
//   zera_s   in  synchronous clear (wins over conta)
//   conta    in  count enable
//   q        out current count (W bits)
module contador_m #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         conta,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (zera_s)     q_d = '0;
    else if (conta) q_d = q_q + W'(1);
  end

  always_ff @(posedge clock or negedge zera_as) begin
    if (!zera_as) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays back the stored game sequence on the leds.
// On iniciar it walks ROM addresses 0..limite, shows each word for T_ON
// cycles, blanks the leds for T_OFF cycles, and pulses pronto after the
// last item.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous reset, active-low
//   pausa     in   (only with PAUSA_EN) freeze playback while high
//   iniciar   in   start request, honoured only when idle
//   limite    in   index of the last item; latched on start
//   endereco  out  ROM address (registered)
//   dado      in   ROM data for endereco, valid the cycle after it is loaded
//   leds      out  displayed word, zero while blank (registered)
//   ocupado   out  high in every state but OCIOSO
//   pronto    out  one-cycle end-of-sequence pulse
//   db_estado out  current state encoding
// Configuration: define PAUSA_EN to add the pausa input.
//
// Handshake: iniciar is a level sampled only in OCIOSO; a request that
// arrives while ocupado is high is dropped, never queued. pronto is the
// completion strobe and is high for exactly one cycle (state FIM).
module exibe_sequencia
  import exibe_pkg::*;
#(
  parameter int T_ON  = 500,
  parameter int T_OFF = 250,
  parameter int TW    = 10
) (
  input  logic              clock,
  input  logic              reset,
`ifdef PAUSA_EN
  input  logic              pausa,
`endif
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  output logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] dado,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic [TW-1:0]     timer;
  logic              zera_s;
  logic              conta;
  logic              hold;

  // The freeze only matters in the playback states; OCIOSO and FIM never
  // consult it, so it cannot stall the start or the pronto pulse.
`ifdef PAUSA_EN
  assign hold = pausa;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    end_d   = end_q;
    leds_d  = leds_q;
    zera_s  = 1'b0;
    conta   = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          state_d = LE_MEM;
          lim_d   = limite;
          end_d   = '0;
        end
      end
      LE_MEM: begin
        // One cycle for the ROM to present the word at endereco.
        if (!hold) begin
          state_d = ACENDE;
          leds_d  = dado;
        end
      end
      ACENDE: begin
        conta = !hold;
        if (!hold && timer == ON_LAST) begin
          zera_s  = 1'b1;
          leds_d  = '0;
          state_d = APAGA;
        end
      end
      APAGA: begin
        conta = !hold;
        if (!hold && timer == OFF_LAST) begin
          zera_s = 1'b1;
          if (end_q == lim_q) begin
            state_d = FIM;
          end else begin
            end_d   = end_q + ADDR_W'(1);
            state_d = LE_MEM;
          end
        end
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= OCIOSO;
      lim_q   <= '0;
      end_q   <= '0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      end_q   <= end_d;
      leds_q  <= leds_d;
    end
  end

  contador_m #(.W(TW)) u_timer (
    .clock   (clock),
    .zera_as (reset),
    .zera_s  (zera_s),
    .conta   (conta),
    .q       (timer)
  );

  assign endereco  = end_q;
  assign leds      = leds_q;
  assign ocupado   = (state_q != OCIOSO);
  assign pronto    = (state_q == FIM);
  assign db_estado = state_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
module tb_exibe_sequencia;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] endereco;
  logic [3:0] dado;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;
`ifdef PAUSA_EN
  logic       pausa;
`endif

  int vecs = 0;
  int errs = 0;

  logic [3:0] rom [16];

  // ROM model: the address register lives in the DUT, so the word for
  // endereco is available during the cycle after endereco is loaded.
  assign dado = rom[endereco];

  exibe_sequencia #(.T_ON(4), .T_OFF(2), .TW(4)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef PAUSA_EN
    .pausa     (pausa),
`endif
    .iniciar   (iniciar),
    .limite    (limite),
    .endereco  (endereco),
    .dado      (dado),
    .leds      (leds),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete run; T_ON=4, T_OFF=2 gives 7 edges per item.
  // After edge n (n>=1) of the run: item=(n-1)/7, phase=(n-1)%7;
  // phases 0..3 show rom[item], phases 4..6 are blank.
  task automatic run_seq(input logic [3:0] lim, input logic keep_start);
    int total;
    int item;
    int ph;
    int exp_addr;
    total = (int'(lim) + 1) * 7;
    @(negedge clock);
    iniciar = 1'b1;
    limite  = lim;
    @(posedge clock); #1;
    check("start_state", 8'(db_estado), 8'h1);
    check("start_addr",  8'(endereco),  8'h0);
    @(negedge clock);
    iniciar = keep_start;
    limite  = ~lim;  // must not affect the run in progress
    for (int n = 1; n <= total; n++) begin
      @(posedge clock); #1;
      item = (n - 1) / 7;
      ph   = (n - 1) % 7;
      exp_addr = (n / 7 > int'(lim)) ? int'(lim) : n / 7;
      check("leds",    8'(leds),     (ph < 4) ? 8'(rom[item]) : 8'h0);
      check("addr",    8'(endereco), 8'(exp_addr));
      check("pronto",  8'(pronto),   (n == total) ? 8'h1 : 8'h0);
      check("ocupado", 8'(ocupado),  8'h1);
    end
    @(posedge clock); #1;
    check("end_ocupado", 8'(ocupado),   8'h0);
    check("end_pronto",  8'(pronto),    8'h0);
    check("end_state",   8'(db_estado), 8'h0);
  endtask

  initial begin
    rom = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h3, 4'h5, 4'h6,
            4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    reset   = 1'b0;
    iniciar = 1'b0;
    limite  = 4'h0;
`ifdef PAUSA_EN
    pausa   = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    check("rst_leds",    8'(leds),      8'h0);
    check("rst_addr",    8'(endereco),  8'h0);
    check("rst_ocupado", 8'(ocupado),   8'h0);
    check("rst_pronto",  8'(pronto),    8'h0);
    check("rst_state",   8'(db_estado), 8'h0);
    @(negedge clock);
    reset = 1'b1;

    // main case: 1,2,4 then pronto at edge 21
    run_seq(4'd2, 1'b0);
    // single item
    run_seq(4'd0, 1'b0);
    // full range, includes a zero word shown as blank
    run_seq(4'd15, 1'b0);

    // iniciar held high: restart only after OCIOSO, on the next edge
    run_seq(4'd1, 1'b1);
    @(posedge clock); #1;
    check("restart_state", 8'(db_estado), 8'h1);
    check("restart_addr",  8'(endereco),  8'h0);
    @(negedge clock);
    iniciar = 1'b0;

    // restart edge was R0; item 1 is in ACENDE after R8, R9
    repeat (9) @(posedge clock);
    #1;
    check("pre_rst_state", 8'(db_estado), 8'h2);
    check("pre_rst_leds",  8'(leds),      8'(rom[1]));
    check("pre_rst_addr",  8'(endereco),  8'h1);
    reset = 1'b0;
    #1;
    check("abort_leds",    8'(leds),      8'h0);
    check("abort_ocupado", 8'(ocupado),   8'h0);
    check("abort_addr",    8'(endereco),  8'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("abort_no_pronto", 8'(pronto), 8'h0);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("idle_after_abort", 8'(db_estado), 8'h0);

`ifdef PAUSA_EN
    // pause 5 cycles in ACENDE of a single-item run: pronto at edge 12
    @(negedge clock);
    iniciar = 1'b1;
    limite  = 4'd0;
    @(posedge clock);
    @(negedge clock);
    iniciar = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    pausa = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("pause_leds",  8'(leds),      8'(rom[0]));
      check("pause_state", 8'(db_estado), 8'h2);
    end
    @(negedge clock);
    pausa = 1'b0;
    // edges 3..7 were paused; edges 8..11 finish the item
    for (int n = 8; n <= 12; n++) begin
      @(posedge clock); #1;
      check("pause_pronto", 8'(pronto), (n == 12) ? 8'h1 : 8'h0);
    end
    @(posedge clock); #1;
    check("pause_end", 8'(ocupado), 8'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
